// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: parametrised pipeline stage register with a valid/ready handshake.
//
// Holds one payload in the main register, which drives out_data directly. With
// SKID=1 it also holds a second payload in a skid register, so that in_ready
// depends only on registered state. With SKID=0 it holds a single entry, and
// in_ready looks through to out_ready combinationally. The flush input drops
// every held payload and loads the bubble value FLUSH_VAL. The hold input
// freezes the stage and masks both sides of the handshake.
//
// Ports:
//   clk        rising-edge clock
//   rst        asynchronous, active-high reset
//   in_valid   upstream payload valid
//   in_ready   stage can accept a payload this cycle
//   in_data    upstream payload (WIDTH bits)
//   out_valid  payload valid to downstream
//   out_ready  downstream accepts this cycle
//   out_data   payload to downstream (WIDTH bits)
//   flush      discard all held payloads, insert a bubble
//   hold       freeze the stage
//   occ        number of entries held (0..2)
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter logic [WIDTH-1:0] FLUSH_VAL = '0,
  parameter bit               SKID      = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  input  logic             flush,
  input  logic             hold,
  output logic [1:0]       occ
);

  logic             main_valid_q, main_valid_d;
  logic             skid_valid_q, skid_valid_d;
  logic [WIDTH-1:0] main_data_q, main_data_d;
  logic [WIDTH-1:0] skid_data_q, skid_data_d;
  logic             in_fire_s;
  logic             out_fire_s;

  // Handshake terms; hold masks both sides.
  always_comb begin
    in_ready = 1'b0;
    if (SKID) begin
      // Only registered state is used here, so there is no out_ready path.
      in_ready = !hold && !skid_valid_q;
    end else begin
      in_ready = !hold && (!main_valid_q || out_ready);
    end
  end

  assign out_valid  = main_valid_q && !hold;
  assign out_data   = main_data_q;
  assign in_fire_s  = in_valid && in_ready;
  assign out_fire_s = out_valid && out_ready;
  assign occ        = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

  // Next-state logic, in priority order: flush, then hold, then the handshake.
  always_comb begin
    main_valid_d = main_valid_q;
    skid_valid_d = skid_valid_q;
    main_data_d  = main_data_q;
    skid_data_d  = skid_data_q;
    if (flush) begin
      // Any word accepted in the same cycle is dropped along with the held ones.
      main_valid_d = 1'b0;
      skid_valid_d = 1'b0;
      main_data_d  = FLUSH_VAL;
    end else if (hold) begin
      // Frozen: keep every register.
      main_valid_d = main_valid_q;
    end else if (SKID) begin
      if (skid_valid_q) begin
        // BOTH: in_ready is low, so only the downstream side can move.
        if (out_fire_s) begin
          main_data_d  = skid_data_q;
          skid_valid_d = 1'b0;
        end else begin
          skid_valid_d = skid_valid_q;
        end
      end else if (main_valid_q) begin
        // FULL
        if (in_fire_s && out_fire_s) begin
          main_data_d = in_data;
        end else if (in_fire_s) begin
          skid_data_d  = in_data;
          skid_valid_d = 1'b1;
        end else if (out_fire_s) begin
          // The payload stays in main_data_q; only the valid bit is cleared.
          main_valid_d = 1'b0;
        end else begin
          main_valid_d = main_valid_q;
        end
      end else begin
        // EMPTY
        if (in_fire_s) begin
          main_data_d  = in_data;
          main_valid_d = 1'b1;
        end else begin
          main_valid_d = main_valid_q;
        end
      end
    end else begin
      // Single entry: accepting a word and delivering one in the same cycle
      // replaces the payload.
      if (in_fire_s) begin
        main_data_d  = in_data;
        main_valid_d = 1'b1;
      end else if (out_fire_s) begin
        main_valid_d = 1'b0;
      end else begin
        main_valid_d = main_valid_q;
      end
    end
  end

  // State registers, cleared asynchronously.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_valid_q <= 1'b0;
      skid_valid_q <= 1'b0;
      main_data_q  <= RESET_VAL;
      skid_data_q  <= RESET_VAL;
    end else begin
      main_valid_q <= main_valid_d;
      skid_valid_q <= skid_valid_d;
      main_data_q  <= main_data_d;
      skid_data_q  <= skid_data_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Directed testbench for pipe_stage_reg. It drives one SKID=1 instance, whose
// bubble value is a NOP (32'h13), and one SKID=0 instance.
module tb_pipe_stage_reg;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        hold;
  // SKID=1 instance
  logic        in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_data, out_data;
  logic [1:0]  occ;
  // SKID=0 instance
  logic        in_valid0, in_ready0, out_valid0, out_ready0;
  logic [31:0] in_data0, out_data0;
  logic [1:0]  occ0;

  int n_checks = 0;
  int n_errors = 0;

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VAL(32'h0000_0000), .FLUSH_VAL(32'h0000_0013), .SKID(1'b1)
  ) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .flush(flush), .hold(hold), .occ(occ)
  );

  pipe_stage_reg #(
    .WIDTH(32), .RESET_VAL(32'h0000_0000), .FLUSH_VAL(32'h0000_0000), .SKID(1'b0)
  ) dut0 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid0), .in_ready(in_ready0), .in_data(in_data0),
    .out_valid(out_valid0), .out_ready(out_ready0), .out_data(out_data0),
    .flush(flush), .hold(hold), .occ(occ0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Advance past the next rising edge; inputs change and outputs are sampled here.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Check the SKID=1 outputs after the inputs have settled.
  task automatic expect1(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] o, input logic r);
    #1;
    check({tag, ".out_valid"}, 32'(out_valid), 32'(v));
    check({tag, ".out_data"},  out_data, d);
    check({tag, ".occ"},       32'(occ), 32'(o));
    check({tag, ".in_ready"},  32'(in_ready), 32'(r));
  endtask

  task automatic expect0(input string tag, input logic v, input logic [31:0] d,
                         input logic [1:0] o, input logic r);
    #1;
    check({tag, ".out_valid0"}, 32'(out_valid0), 32'(v));
    check({tag, ".out_data0"},  out_data0, d);
    check({tag, ".occ0"},       32'(occ0), 32'(o));
    check({tag, ".in_ready0"},  32'(in_ready0), 32'(r));
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; hold = 1'b0;
    in_valid = 1'b1; in_data = 32'hDEAD_BEEF; out_ready = 1'b1;
    in_valid0 = 1'b0; in_data0 = 32'h0; out_ready0 = 1'b0;

    // Reset with traffic on the input.
    tick(); tick();
    expect1("rst_held", 1'b0, 32'h0, 2'd0, 1'b1);
    rst = 1'b0;
    expect1("rst_rel", 1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    expect1("first_word", 1'b1, 32'hDEAD_BEEF, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    expect1("drain0", 1'b0, 32'hDEAD_BEEF, 2'd0, 1'b1);

    // Streaming: one word per cycle, with one cycle of latency.
    for (int i = 1; i <= 4; i++) begin
      in_valid = 1'b1; in_data = 32'(i);
      tick();
      expect1($sformatf("stream%0d", i), 1'b1, 32'(i), 2'd1, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    expect1("stream_end", 1'b0, 32'h4, 2'd0, 1'b1);

    // Backpressure fills the skid entry; the words then drain in order.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'hA;
    tick();
    expect1("bp_a", 1'b1, 32'hA, 2'd1, 1'b1);
    in_data = 32'hB;
    tick();
    expect1("bp_b", 1'b1, 32'hA, 2'd2, 1'b0);
    in_data = 32'hC;
    tick();
    expect1("bp_c_held", 1'b1, 32'hA, 2'd2, 1'b0);
    out_ready = 1'b1;
    expect1("bp_out_a", 1'b1, 32'hA, 2'd2, 1'b0);
    tick();
    expect1("bp_out_b", 1'b1, 32'hB, 2'd1, 1'b1);
    tick();
    expect1("bp_out_c", 1'b1, 32'hC, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    expect1("bp_end", 1'b0, 32'hC, 2'd0, 1'b1);

    // Flush while in BOTH: the bubble payload is loaded and 0x7 never appears.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h5;
    tick();
    in_data = 32'h6;
    tick();
    expect1("fl_both", 1'b1, 32'h5, 2'd2, 1'b0);
    flush = 1'b1; in_data = 32'h7;
    tick();
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    expect1("fl_after", 1'b0, 32'h13, 2'd0, 1'b1);
    tick();
    expect1("fl_no7", 1'b0, 32'h13, 2'd0, 1'b1);

    // Flush from FULL, with a real in_fire in the same cycle: that word is dropped.
    out_ready = 1'b0; in_valid = 1'b1; in_data = 32'h8;
    tick();
    flush = 1'b1; in_data = 32'h7;
    expect1("fl_full_pre", 1'b1, 32'h8, 2'd1, 1'b1);
    tick();
    flush = 1'b0; in_valid = 1'b0;
    expect1("fl_full_post", 1'b0, 32'h13, 2'd0, 1'b1);

    // Hold for three cycles at occ=1; nothing moves.
    out_ready = 1'b1; in_valid = 1'b1; in_data = 32'h9;
    tick();
    hold = 1'b1; in_data = 32'hA0;
    expect1("hold_on", 1'b0, 32'h9, 2'd1, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      expect1($sformatf("hold%0d", i), 1'b0, 32'h9, 2'd1, 1'b0);
    end
    hold = 1'b0;
    expect1("hold_rel", 1'b1, 32'h9, 2'd1, 1'b1);
    tick();
    expect1("hold_next", 1'b1, 32'hA0, 2'd1, 1'b1);
    in_valid = 1'b0;
    tick();
    expect1("hold_end", 1'b0, 32'hA0, 2'd0, 1'b1);

    // A flush asserted during hold still clears the stage.
    in_valid = 1'b1; in_data = 32'h55; out_ready = 1'b0;
    tick();
    in_valid = 1'b0; hold = 1'b1; flush = 1'b1;
    tick();
    hold = 1'b0; flush = 1'b0;
    expect1("fl_hold", 1'b0, 32'h13, 2'd0, 1'b1);

    // SKID=0 instance: in_ready follows out_ready combinationally.
    out_ready0 = 1'b0; in_valid0 = 1'b1; in_data0 = 32'h11;
    expect0("s0_empty", 1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    expect0("s0_full", 1'b1, 32'h11, 2'd1, 1'b0);
    in_data0 = 32'h22;
    tick();
    expect0("s0_stall", 1'b1, 32'h11, 2'd1, 1'b0);
    out_ready0 = 1'b1;
    expect0("s0_ready_up", 1'b1, 32'h11, 2'd1, 1'b1);
    tick();
    expect0("s0_replace22", 1'b1, 32'h22, 2'd1, 1'b1);
    in_data0 = 32'h33;
    tick();
    expect0("s0_replace33", 1'b1, 32'h33, 2'd1, 1'b1);
    in_valid0 = 1'b0;
    tick();
    expect0("s0_end", 1'b0, 32'h33, 2'd0, 1'b1);

    // Asynchronous reset in the middle of a cycle clears the valids at once.
    in_valid = 1'b1; in_data = 32'h77; out_ready = 1'b0;
    tick();
    expect1("ar_pre", 1'b1, 32'h77, 2'd1, 1'b1);
    #2 rst = 1'b1;
    expect1("ar_now", 1'b0, 32'h0, 2'd0, 1'b1);
    tick();
    rst = 1'b0;
    tick();
    expect1("ar_first", 1'b1, 32'h77, 2'd1, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
